// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//  Bundles the fetch stage's bus-level signals: instruction-memory read port,
//  redirect input from execute, the decode valid/ready handshake, loader hold
//  and the misaligned-fetch fault flag.
//  master : fetch_unit side (drives imem_en/imem_addr, if_valid/if_pc/if_instr, fetch_fault)
//  slave  : environment side (imem, execute, decode, loader)
interface fetch_unit_if;
  logic        hold;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_fault;

  modport master (
    input  hold,
    output imem_en,
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr,
    output fetch_fault
  );

  modport slave (
    output hold,
    input  imem_en,
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//  Instruction-fetch stage. Owns the fetch PC, issues word reads to a memory
//  with a 1-cycle registered read, buffers returned {pc, instr} pairs in a
//  small FIFO and presents the head to decode over valid/ready. Redirects from
//  execute flush everything buffered or in flight and restart fetch.
//  Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on misaligned redirect
//  instead of silently aligning the target).
// Ports
//  clk   : clock, all state on posedge
//  rstn  : synchronous reset, active-low
//  bus   : fetch_unit_if.master (hold, imem_*, redirect_*, if_*, fetch_fault)
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal fetching
// FAULT | misaligned redirect trapped; no issue until an aligned redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  fetch_unit_if.master bus
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, FAULT} state_t;

  state_t             state, state_nxt;
  logic [31:0]        fetch_pc;
  logic               inflight;
  logic [31:0]        inflight_pc;
  logic [31:0]        fifo_pc    [BUF_DEPTH];
  logic [31:0]        fifo_instr [BUF_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   occ;
  logic [CNT_W:0]     pending;
  logic               head_valid;
  logic               pop, push, issue, room, misalign;
  logic [31:0]        redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_target = bus.redirect_pc;
  assign misalign        = bus.redirect_pc[1:0] != 2'b00;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^bus.redirect_pc[1:0];
  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
  assign misalign        = 1'b0;
`endif

  assign head_valid = occ != '0;
  assign pop        = head_valid & bus.if_ready;
  // A redirect flushes the FIFO, so the response arriving in that cycle is dropped there.
  assign push       = inflight;

  // Slots already claimed (buffered + in flight) after this cycle's pop; the
  // in-flight response always owns a slot, so issuing only below depth can't overflow.
  assign pending = {1'b0, occ} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign room    = pending < (CNT_W+1)'(BUF_DEPTH);

  always_ff @(posedge clk) begin
    if (!rstn) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      RUN: begin
        if (bus.redirect_valid && misalign) state_nxt = FAULT;
        issue = rstn & ~bus.hold & ~bus.redirect_valid & room;
      end
      FAULT: begin
        if (bus.redirect_valid && !misalign) state_nxt = RUN;
      end
    endcase
  end

  assign bus.imem_en     = issue;
  assign bus.imem_addr   = fetch_pc;
  assign bus.fetch_fault = state == FAULT;
  assign bus.if_valid    = head_valid;
  assign bus.if_pc       = head_valid ? fifo_pc[rd_ptr]    : 32'h0;
  assign bus.if_instr    = head_valid ? fifo_instr[rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= redirect_target;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while occ covers them.
  always_ff @(posedge clk) begin
    if (rstn && !bus.redirect_valid && push) begin
      fifo_pc[wr_ptr]    <= inflight_pc;
      fifo_instr[wr_ptr] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//  Self-checking bench for fetch_unit. A queue of issued-but-unconsumed PCs
//  (each tagged with its issue cycle) models the stage: an entry becomes
//  visible two cycles after issue, issue is allowed while fewer than two
//  entries remain after this cycle's pop, and a redirect or reset empties it.
//  Ports: none (instantiates fetch_unit_if and fetch_unit).
module tb_fetch_unit;

  logic clk;
  logic rstn;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  // Instruction memory: 1-cycle registered read.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] q_pc [$];
  int          q_t  [$];
  logic [31:0] m_pc;
  logic        m_fault;
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r_n, input logic h, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    logic        exp_valid, exp_en, pop;
    logic [31:0] exp_pc, exp_instr;
    int          pend;
    @(negedge clk);
    rstn               = r_n;
    bus.hold           = h;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.if_ready       = rdy;
    #1;
    exp_valid = (q_pc.size() > 0) && (q_t[0] + 2 <= cyc);
    exp_pc    = exp_valid ? q_pc[0] : 32'h0;
    exp_instr = exp_valid ? mem_word(q_pc[0]) : 32'h0;
    pop       = exp_valid & rdy;
    pend      = q_pc.size() - (pop ? 1 : 0);
    exp_en    = r_n && !m_fault && !h && !rv && (pend < 2);
    chk("if_valid",    {31'b0, bus.if_valid},    {31'b0, exp_valid});
    chk("if_pc",       bus.if_pc,                exp_pc);
    chk("if_instr",    bus.if_instr,             exp_instr);
    chk("imem_en",     {31'b0, bus.imem_en},     {31'b0, exp_en});
    chk("imem_addr",   bus.imem_addr,            m_pc);
    chk("fetch_fault", {31'b0, bus.fetch_fault}, {31'b0, m_fault});
    if (!r_n) begin
      q_pc.delete(); q_t.delete();
      m_pc = 32'h0; m_fault = 1'b0; cyc = 0;
    end else begin
      if (rv) begin
        q_pc.delete(); q_t.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        m_pc    = rpc;
        m_fault = rpc[1:0] != 2'b00;
`else
        m_pc    = rpc & 32'hFFFF_FFFC;
`endif
      end else begin
        if (pop) begin
          void'(q_pc.pop_front());
          void'(q_t.pop_front());
        end
        if (exp_en) begin
          q_pc.push_back(m_pc);
          q_t.push_back(cyc);
          m_pc = m_pc + 32'd4;
        end
      end
      cyc++;
    end
  endtask

  initial begin
    rstn               = 1'b0;
    bus.hold           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b1;
    bus.imem_rdata     = 32'h0;
    m_pc = 32'h0; m_fault = 1'b0; cyc = 0;
    repeat (3) @(posedge clk);

    // Reset then streaming with decode always ready.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (12) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Back-pressure from cycle 2 for five cycles.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect mid-stream.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Hold for four cycles mid-stream.
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Misaligned redirect, then aligned recovery.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0102, 1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Address wrap.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset in the middle of back-pressured traffic.
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic        r_n, h, rv, rdy;
      logic [31:0] rpc;
      r_n = ($urandom_range(63) != 0);
      h   = ($urandom_range(5) == 0);
      rv  = ($urandom_range(11) == 0);
      rdy = ($urandom_range(2) != 0);
      rpc = $urandom();
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      step(r_n, h, rv, rpc, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
